// File: rtl/f1_pkg.sv
// Shared types and constants for the F1 reaction timer.
package f1_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ARMED = 3'd1,
        HOLD  = 3'd2,
        GO    = 3'd3,
        DONE  = 3'd4,
        FALSE = 3'd5
    } state_t;

    localparam logic [7:0] ALL_ON  = 8'hFF;
    localparam logic [7:0] ALL_OFF = 8'h00;

    // x^7+x^3+1: feedback from bits 6 and 2
    localparam logic [6:0] LFSR_TAPS = 7'h44;
    localparam logic [6:0] LFSR_SEED = 7'h01;

endpackage

// File: rtl/lfsr7.sv
// Free-running Fibonacci LFSR used to randomise the lights-out hold.
module lfsr7
    import f1_pkg::*;
#(
    parameter int unsigned W = 7
) (
    input  logic         clk,
    input  logic         rst_n,
    output logic [W-1:0] q
);

    localparam logic [W-1:0] TAPS = W'(LFSR_TAPS);
    localparam logic [W-1:0] SEED = W'(LFSR_SEED);

    logic [W-1:0] r_q;

    // Shift every cycle; nonzero seed keeps the register out of the all-zero lockup.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= SEED;
        end else begin
            r_q <= {r_q[W-2:0], ^(r_q & TAPS)};
        end
    end

    assign q = r_q;

endmodule

// File: rtl/f1_reaction_timer.sv
// F1 reaction timer: waits for all lights, random hold, lights out, times the button.
module f1_reaction_timer
    import f1_pkg::*;
#(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned LFSR_W    = 7,
    parameter int unsigned MIN_DELAY = 200
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             start,
    input  logic [7:0]       lights_in,
    input  logic             btn,
    output logic [7:0]       lights_out,
    output logic [WIDTH-1:0] result,
    output logic             result_valid,
    output logic             false_start,
    output logic             busy
);

    localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};

    state_t             r_state;
    logic [WIDTH-1:0]   r_delay;
    logic [WIDTH-1:0]   r_count;
    logic [WIDTH-1:0]   r_result;
    logic               r_result_valid;
    logic               r_false_start;
    logic               r_busy;
    logic [7:0]         r_lights_out;
    logic               r_btn_q;

    state_t             w_state_nxt;
    logic [WIDTH-1:0]   w_delay_nxt;
    logic [WIDTH-1:0]   w_count_nxt;
    logic [WIDTH-1:0]   w_result_nxt;
    logic               w_valid_nxt;
    logic               w_fs_nxt;
    logic               w_busy_nxt;
    logic [7:0]         w_lights_nxt;
    logic [LFSR_W-1:0]  w_lfsr;
    logic               w_press;

    lfsr7 #(.W(LFSR_W)) u_lfsr (
        .clk   (clk),
        .rst_n (rst),
        .q     (w_lfsr)
    );

    assign w_press = btn & ~r_btn_q;

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state        <= IDLE;
            r_delay        <= '0;
            r_count        <= '0;
            r_result       <= '0;
            r_result_valid <= 1'b0;
            r_false_start  <= 1'b0;
            r_busy         <= 1'b0;
            r_lights_out   <= ALL_OFF;
            r_btn_q        <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_delay        <= w_delay_nxt;
            r_count        <= w_count_nxt;
            r_result       <= w_result_nxt;
            r_result_valid <= w_valid_nxt;
            r_false_start  <= w_fs_nxt;
            r_busy         <= w_busy_nxt;
            r_lights_out   <= w_lights_nxt;
            r_btn_q        <= btn;
        end
    end

    // Next-state and next-output logic; outputs follow the state being entered.
    always_comb begin
        w_state_nxt  = r_state;
        w_delay_nxt  = r_delay;
        w_count_nxt  = r_count;
        w_result_nxt = r_result;
        w_valid_nxt  = r_result_valid;
        w_fs_nxt     = r_false_start;
        w_busy_nxt   = 1'b0;
        w_lights_nxt = ALL_OFF;

        case (r_state)
            IDLE, DONE, FALSE: begin
                if (start) begin
                    w_state_nxt  = ARMED;
                    w_result_nxt = '0;
                    w_valid_nxt  = 1'b0;
                    w_fs_nxt     = 1'b0;
                end
            end
            ARMED: begin
                if (w_press) begin
                    w_state_nxt  = FALSE;
                    w_result_nxt = '0;
                    w_fs_nxt     = 1'b1;
                end else if (lights_in == ALL_ON) begin
                    w_state_nxt = HOLD;
                    w_delay_nxt = WIDTH'(MIN_DELAY) + WIDTH'(w_lfsr);
                end
            end
            HOLD: begin
                if (w_press) begin
                    w_state_nxt  = FALSE;
                    w_result_nxt = '0;
                    w_fs_nxt     = 1'b1;
                end else if (tick) begin
                    if (r_delay == '0) begin
                        w_state_nxt = GO;
                        w_count_nxt = '0;
                    end else begin
                        w_delay_nxt = r_delay - WIDTH'(1);
                    end
                end
            end
            GO: begin
                // A press on a tick cycle reports the count before that tick.
                if (w_press) begin
                    w_state_nxt  = DONE;
                    w_result_nxt = r_count;
                    w_valid_nxt  = 1'b1;
                end else if (tick && (r_count != CNT_MAX)) begin
                    w_count_nxt = r_count + WIDTH'(1);
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        case (w_state_nxt)
            ARMED: begin
                w_busy_nxt   = 1'b1;
                w_lights_nxt = lights_in;
            end
            HOLD: begin
                w_busy_nxt   = 1'b1;
                w_lights_nxt = ALL_ON;
            end
            GO: begin
                w_busy_nxt   = 1'b1;
            end
            default: begin
                w_busy_nxt   = 1'b0;
            end
        endcase
    end

    assign lights_out   = r_lights_out;
    assign result       = r_result;
    assign result_valid = r_result_valid;
    assign false_start  = r_false_start;
    assign busy         = r_busy;

endmodule
